lisp_executor: RTL and testbench
================================

# lisp_executor

Downstream consumer of the 24-bit instruction stack. On `start`, it pops instruction words one at a time and evaluates them as a postfix program on an internal 16-bit operand stack until it reaches HALT. At HALT it presents the top of the operand stack as `result`. This block is the arithmetic back end of the Lisp-style ALU. The upstream parser pushes a program in reverse order, so pops return it in postfix order.

## Interface

Parameters:
- `DATA_W`, 16: operand, immediate and result width.
- `OPS_DEPTH`, 8: operand stack entries.
- `MAX_INSTR`, 255: instructions executed before the runaway error fires.

Ports:
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin evaluation; sampled only in IDLE, DONE or ERROR.
- `stk_pop` output 1: one-cycle pop request to the instruction stack.
- `stk_data` input 24: instruction stack output word.
- `busy` output 1: high from the cycle after `start` is accepted until DONE or ERROR.
- `done` output 1: high while in DONE.
- `error` output 1: high while in ERROR.
- `err_code` output 2: 0 none, 1 operand underflow, 2 operand overflow or illegal opcode, 3 runaway.
- `result` output DATA_W: HALT result; holds its value until the next accepted `start`.
- `depth` output 4: current operand stack occupancy.

## Operation

- Instruction format:
  - [23:20] opcode.
  - [19:16] reserved, ignored.
  - [15:0] immediate.
- Opcodes:
  - 0 NOP.
  - 1 PUSHI: push the immediate.
  - 2 ADD, 3 SUB, 4 MUL (low DATA_W bits kept), 5 AND, 6 OR, 7 XOR.
  - 8 NEG: two's complement of the top entry, in place.
  - F HALT.
  - 9–E illegal.
- Binary ops:
  - b = top, a = next; pop both, push a op b.
  - SUB computes a−b. All arithmetic wraps modulo 2^DATA_W.
- Error checks, evaluated in EXEC before any state change:
  - Binary op with depth<2, NEG with depth<1, or HALT with depth=0: underflow, code 1.
  - PUSHI with depth=OPS_DEPTH: code 2.
  - Illegal opcode: code 2.
  - Instruction count reaching MAX_INSTR without HALT: code 3.
- On error the operand stack is left unchanged.
- FSM:
  - IDLE: `start` clears depth and the instruction count, clears `result`, → POP.
  - POP: assert `stk_pop` for this cycle only, → WAIT.
  - WAIT: → CAPTURE.
  - CAPTURE: register `stk_data` into the instruction register at the end of this cycle, → EXEC.
  - EXEC: decode and execute, increment the instruction count.
    - HALT → DONE with `result` = top.
    - Error → ERROR.
    - Otherwise → POP.
  - DONE and ERROR: hold. `start` behaves as in IDLE.
- `err_code` is sticky until the next accepted `start` or reset.
- Upstream must not push while `busy` is high. The executor never pops while not busy.
- The executor does not track instruction stack emptiness. A program without HALT is caught only by the runaway limit.

## Timing

- Reset values: state IDLE, `stk_pop`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `result`=0, `depth`=0.
- Reset takes effect immediately at any point, including mid-program. No pop is issued after `reset_n` falls.
- Pop handshake: `stk_pop` is high in cycle C0. The stack word is valid only during C2 and is sampled at the end of C2. No pop is issued in C1 or C2.
- Per-instruction latency is 4 cycles (POP, WAIT, CAPTURE, EXEC).
- Start to first `stk_pop` is 1 cycle.
- A program of N instructions ending in HALT asserts `done` 4N+1 cycles after the `start` edge.
- `result` and `done` update on the same edge.
- `start` held high across DONE restarts exactly once per accepted edge. While `busy` is high, `start` is ignored.

## Test plan

- Reset mid-run: assert `reset_n`=0 during WAIT → all outputs 0 and `stk_pop` low within the same cycle. After release the block sits in IDLE.
- Basic sum: pop order PUSHI 5, PUSHI 7, ADD, HALT → `result`=12 and `done` at cycle 17. Exactly 4 `stk_pop` pulses, each followed by 2 idle cycles.
- Wrap and SUB: PUSHI 3, PUSHI 5, SUB, HALT → `result`=0xFFFE. Separately, PUSHI 0x8000, PUSHI 2, MUL, HALT → `result`=0.
- Underflow: PUSHI 1, ADD → `error`=1, `err_code`=1, `depth`=1 with the stack unchanged. A following `start` clears the error.
- Overflow and illegal: 9 consecutive PUSHI → `err_code`=2 on the 9th with `depth`=8. A single opcode 0xA → `err_code`=2.
- Runaway: feed NOP forever → `error` with `err_code`=3 after the 255th EXEC, and no further `stk_pop`.

Source files
------------

// File: rtl/lisp_executor.sv
// lisp_executor: pops 24-bit instruction words from the upstream instruction
// stack and evaluates them as a postfix program on a small operand stack.
// HALT presents the top of the operand stack on result. Each instruction takes
// four cycles: pop request, stack read latency, capture, execute.
module lisp_executor #(
    parameter int DATA_W    = 16,
    parameter int OPS_DEPTH = 8,
    parameter int MAX_INSTR = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              stk_pop,
    input  logic [23:0]       stk_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        depth
);

    localparam int IDX_W = (OPS_DEPTH > 1) ? $clog2(OPS_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_INSTR + 1);
    localparam logic [3:0]       FULL      = 4'(OPS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_INSTR);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NEG   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_CAPT,
        S_EXEC,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic                stk_pop_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [1:0]          err_code_q;
    logic [DATA_W-1:0]   result_q;
    logic [3:0]          depth_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [23:0]         instr_q;

    logic [DATA_W-1:0]   stack_mem [OPS_DEPTH];

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    nxt_idx;
    logic [DATA_W-1:0]   top_val;
    logic [DATA_W-1:0]   nxt_val;
    logic                exec_err;
    logic [1:0]          exec_code;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_val;
    logic [3:0]          depth_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                runaway;
    logic                stack_we;

    assign opcode  = instr_q[23:20];
    assign imm     = instr_q[DATA_W-1:0];
    assign top_idx = IDX_W'(depth_q - 4'd1);
    assign nxt_idx = IDX_W'(depth_q - 4'd2);
    assign top_val = stack_mem[top_idx];
    assign nxt_val = stack_mem[nxt_idx];
    assign cnt_d   = cnt_q + 1'b1;
    // The limit applies only to an instruction that would otherwise continue.
    assign runaway = (cnt_d == CNT_LIMIT);

    // Decode the captured instruction: legality checks and the stack update it would make.
    always_comb begin
        exec_err  = 1'b0;
        exec_code = 2'd0;
        wr_en     = 1'b0;
        wr_idx    = IDX_W'(depth_q);
        wr_val    = imm;
        depth_d   = depth_q;
        case (opcode)
            OP_NOP: begin
            end
            OP_PUSHI: begin
                if (depth_q == FULL) begin
                    exec_err  = 1'b1;
                    exec_code = 2'd2;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = IDX_W'(depth_q);
                    wr_val  = imm;
                    depth_d = depth_q + 4'd1;
                end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                if (depth_q < 4'd2) begin
                    exec_err  = 1'b1;
                    exec_code = 2'd1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = nxt_idx;
                    depth_d = depth_q - 4'd1;
                    case (opcode)
                        OP_ADD:  wr_val = nxt_val + top_val;
                        OP_SUB:  wr_val = nxt_val - top_val;
                        OP_MUL:  wr_val = nxt_val * top_val;
                        OP_AND:  wr_val = nxt_val & top_val;
                        OP_OR:   wr_val = nxt_val | top_val;
                        default: wr_val = nxt_val ^ top_val;
                    endcase
                end
            end
            OP_NEG: begin
                if (depth_q == 4'd0) begin
                    exec_err  = 1'b1;
                    exec_code = 2'd1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                    wr_val = '0 - top_val;
                end
            end
            OP_HALT: begin
                if (depth_q == 4'd0) begin
                    exec_err  = 1'b1;
                    exec_code = 2'd1;
                end
            end
            default: begin
                exec_err  = 1'b1;
                exec_code = 2'd2;
            end
        endcase
    end

    // Errors and the runaway stop both leave the operand stack untouched.
    assign stack_we = (state_q == S_EXEC) && wr_en && !exec_err && !runaway;

    // Operand stack storage; no reset needed since depth gates every read.
    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_mem[wr_idx] <= wr_val;
        end
    end

    // Control FSM with registered outputs; start is honoured only when not busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            stk_pop_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            result_q   <= '0;
            depth_q    <= 4'd0;
            cnt_q      <= '0;
            instr_q    <= 24'd0;
        end else begin
            stk_pop_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        depth_q    <= 4'd0;
                        cnt_q      <= '0;
                        result_q   <= '0;
                        err_code_q <= 2'd0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        stk_pop_q  <= 1'b1;
                        state_q    <= S_POP;
                    end
                end
                S_POP: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    instr_q <= stk_data;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    cnt_q <= cnt_d;
                    if (exec_err) begin
                        error_q    <= 1'b1;
                        err_code_q <= exec_code;
                        busy_q     <= 1'b0;
                        state_q    <= S_ERR;
                    end else if (opcode == OP_HALT) begin
                        result_q <= top_val;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (runaway) begin
                        error_q    <= 1'b1;
                        err_code_q <= 2'd3;
                        busy_q     <= 1'b0;
                        state_q    <= S_ERR;
                    end else begin
                        depth_q   <= depth_d;
                        stk_pop_q <= 1'b1;
                        state_q   <= S_POP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stk_pop  = stk_pop_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign result   = result_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_lisp_executor.sv
// Testbench for lisp_executor: directed programs from the test plan plus
// random postfix programs, compared against a queue-based evaluator.
module tb_lisp_executor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] stk_data = 24'd0;
    logic        stk_pop;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] result;
    logic [3:0]  depth;

    lisp_executor #(.DATA_W(16), .OPS_DEPTH(8), .MAX_INSTR(255)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stk_pop  (stk_pop),
        .stk_data (stk_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .result   (result),
        .depth    (depth)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Upstream stack model: word valid only two cycles after the pop cycle.
    logic [23:0] prog_q[$];
    logic [23:0] cur[$];
    logic [23:0] pend = 24'd0;
    int          pop_cnt = 0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (stk_pop) begin
            check_val("pop_gap", wait_cnt, 0);
            pop_cnt++;
            pend     = (prog_q.size() > 0) ? prog_q.pop_front() : 24'h000000;
            wait_cnt = 2;
            stk_data = 24'($urandom);
        end else if (wait_cnt == 2) begin
            wait_cnt = 1;
            stk_data = 24'($urandom);
        end else if (wait_cnt == 1) begin
            wait_cnt = 0;
            stk_data = pend;
        end else begin
            stk_data = 24'($urandom);
        end
    end

    function automatic logic [23:0] mk(input logic [3:0] op, input logic [15:0] imm);
        logic [3:0] rsv;
        rsv = 4'($urandom);
        return {op, rsv, imm};
    endfunction

    // Reference evaluator: runs the program as a postfix stack machine.
    task automatic model(output int n, output bit is_done, output int code,
                         output logic [15:0] res, output int dep);
        logic [15:0] st[$];
        logic [23:0] w;
        logic [3:0]  op;
        logic [15:0] a, b, v;
        int e;
        n = 0; is_done = 0; code = 0; res = 16'd0;
        for (int k = 1; k <= 255; k++) begin
            w  = (k <= cur.size()) ? cur[k-1] : 24'h000000;
            op = w[23:20];
            n  = k;
            e  = 0;
            if (op == 4'h0) e = 0;
            else if (op == 4'h1) e = (st.size() == 8) ? 2 : 0;
            else if (op >= 4'h2 && op <= 4'h7) e = (st.size() < 2) ? 1 : 0;
            else if (op == 4'h8) e = (st.size() < 1) ? 1 : 0;
            else if (op == 4'hF) e = (st.size() == 0) ? 1 : 0;
            else e = 2;
            if (e != 0) begin code = e; break; end
            if (op == 4'hF) begin is_done = 1; res = st[st.size()-1]; break; end
            if (k == 255) begin code = 3; break; end
            if (op == 4'h1) st.push_back(w[15:0]);
            else if (op == 4'h8) st[st.size()-1] = 16'(0 - st[st.size()-1]);
            else if (op != 4'h0) begin
                b = st.pop_back();
                a = st.pop_back();
                case (op)
                    4'h2: v = a + b;
                    4'h3: v = a - b;
                    4'h4: v = 16'(a * b);
                    4'h5: v = a & b;
                    4'h6: v = a | b;
                    default: v = a ^ b;
                endcase
                st.push_back(v);
            end
        end
        dep = st.size();
    endtask

    // Run the program in cur from a start pulse and compare every outcome.
    task automatic run(input string name, input bit poke);
        int n, code, dep, cyc;
        bit is_done;
        logic [15:0] res;
        model(n, is_done, code, res, dep);
        @(negedge clk); #1;
        prog_q  = cur;
        pop_cnt = 0;
        start   = 1'b1;
        @(negedge clk); #1;
        cyc   = 1;
        start = 1'b0;
        check_val({name, ":busy1"}, busy, 1);
        check_val({name, ":pop1"}, stk_pop, 1);
        check_val({name, ":clr"}, {error, done, err_code, result}, 0);
        while (!(done || error) && cyc < 1100) begin
            @(negedge clk); #1;
            cyc++;
            if (poke && cyc == 2) start = 1'b1;
            if (cyc == 4) start = 1'b0;
        end
        check_val({name, ":cyc"}, cyc, 4 * n + 1);
        check_val({name, ":done"}, done, is_done);
        check_val({name, ":error"}, error, !is_done);
        check_val({name, ":code"}, err_code, code);
        check_val({name, ":result"}, result, res);
        check_val({name, ":depth"}, depth, dep);
        check_val({name, ":busy0"}, busy, 0);
        repeat (8) begin @(negedge clk); #1; end
        check_val({name, ":pops"}, pop_cnt, n);
        check_val({name, ":hold"}, {done, error, err_code}, {is_done, !is_done, 2'(code)});
        $display("run %s: n=%0d done=%0d code=%0d result=%04h depth=%0d cycles=%0d",
                 name, n, done, err_code, result, depth, cyc);
    endtask

    initial begin
        int gd, len, r;
        logic [15:0] imm;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_outs", {stk_pop, busy, done, error, err_code, result, depth}, 0);
        reset_n = 1'b1;

        cur = {mk(1, 5), mk(1, 7), mk(2, 0), mk(15, 0)};
        run("sum", 0);
        cur = {mk(1, 3), mk(1, 5), mk(3, 0), mk(15, 0)};
        run("sub_wrap", 0);
        cur = {mk(1, 16'h8000), mk(1, 2), mk(4, 0), mk(15, 0)};
        run("mul_wrap", 1);
        cur = {mk(1, 1), mk(2, 0)};
        run("underflow", 0);
        cur = {mk(1, 16'h00F0), mk(8, 0), mk(15, 0)};
        run("neg", 0);
        cur = {};
        for (int i = 0; i < 9; i++) cur.push_back(mk(1, 16'(i)));
        run("overflow", 0);
        cur = {mk(4'hA, 16'h1234)};
        run("illegal", 0);
        cur = {mk(15, 0)};
        run("halt_empty", 0);
        cur = {};
        run("runaway", 0);

        // Reset while the third instruction is in its read-latency cycle.
        cur = {mk(1, 9), mk(1, 4), mk(2, 0), mk(15, 0)};
        @(negedge clk); #1;
        prog_q  = cur;
        pop_cnt = 0;
        start   = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(negedge clk); #1; end
        check_val("mid:depth_pre", depth, 2);
        check_val("mid:busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check_val("mid:outs", {stk_pop, busy, done, error, err_code, result, depth}, 0);
        repeat (3) begin @(negedge clk); #1; end
        reset_n = 1'b1;
        repeat (6) begin @(negedge clk); #1; end
        check_val("mid:idle", {busy, done, error, stk_pop}, 0);
        check_val("mid:pops", pop_cnt, 3);
        $display("run reset_mid: pops=%0d busy=%0d", pop_cnt, busy);

        // Random programs, biased towards legal sequences.
        for (int t = 0; t < 40; t++) begin
            cur = {};
            gd  = 0;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                r   = $urandom_range(0, 99);
                imm = 16'($urandom);
                if ($urandom_range(0, 3) == 0) imm = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
                if (r < 35 || (gd < 2 && r < 80)) begin
                    cur.push_back(mk(1, imm)); gd++;
                end else if (r < 80) begin
                    cur.push_back(mk(4'($urandom_range(2, 7)), imm)); gd--;
                end else if (r < 88) begin
                    cur.push_back(mk(8, imm));
                end else if (r < 92) begin
                    cur.push_back(mk(0, imm));
                end else if (r < 95) begin
                    cur.push_back(mk(4'($urandom_range(9, 14)), imm));
                end else begin
                    cur.push_back(mk(15, imm));
                end
            end
            if ($urandom_range(0, 99) < 85) cur.push_back(mk(15, 16'($urandom)));
            run($sformatf("rnd%0d", t), $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
